// File: rtl/game_sequencer.sv
// Basketball game clock sequencer: MM:SS countdown, period stepping, breaks and end buzzer.
// Optional shot clock is built only when SHOT_CLOCK_EN is defined.
module game_sequencer #(
  parameter int TICK_DIV    = 100000000,
  parameter int PERIOD_MIN  = 12,
  parameter int NUM_PERIODS = 4,
  parameter int BREAK_SEC   = 60,
  parameter int BUZZ_CYC    = 50000000,
  parameter int SHOT_SEC    = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       shot_reset,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] period,
  output logic [2:0] state,
  output logic       run,
  output logic       score_en,
  output logic       buzzer,
  output logic       game_over,
  output logic [4:0] shot_sec
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN        = 3'd1,
    PAUSED     = 3'd2,
    PERIOD_END = 3'd3,
    BREAK      = 3'd4,
    FINAL      = 3'd5
  } state_t;

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BREAK_SEC + 1);
  localparam int ZW = $clog2(BUZZ_CYC + 1);

  state_t          fsm;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   brk_cnt;
  logic [ZW-1:0]   buzz_cnt;
  logic            tick;
  logic            game_end;
  logic            shot_expire;
  logic            buzz_trig;

  assign state     = fsm;
  assign tick      = ((fsm == RUN) || (fsm == BREAK)) && (tick_cnt == TW'(TICK_DIV - 1));
  assign game_end  = (fsm == RUN) && tick && (minutes == 6'd0) && (seconds == 6'd1);
  assign buzz_trig = game_end || shot_expire;

  // {run, score_en, game_over} as a function of the state being entered
  function automatic logic [2:0] flags_of(input state_t s);
    return {s == RUN, (s == RUN) || (s == PAUSED), s == FINAL};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      period    <= 3'd1;
      minutes   <= 6'(PERIOD_MIN);
      seconds   <= 6'd0;
      tick_cnt  <= '0;
      brk_cnt   <= '0;
      run       <= 1'b0;
      score_en  <= 1'b0;
      game_over <= 1'b0;
    end else if (new_game) begin
      fsm       <= IDLE;
      period    <= 3'd1;
      minutes   <= 6'(PERIOD_MIN);
      seconds   <= 6'd0;
      tick_cnt  <= '0;
      brk_cnt   <= '0;
      run       <= 1'b0;
      score_en  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            fsm <= RUN;
            {run, score_en, game_over} <= flags_of(RUN);
          end
        end
        RUN: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (tick) begin
            if (seconds != 6'd0) begin
              seconds <= seconds - 6'd1;
            end else begin
              minutes <= minutes - 6'd1;
              seconds <= 6'd59;
            end
          end
          // The game clock reaching zero beats a pause or shot-clock expiry on the same tick
          if (game_end) begin
            fsm <= PERIOD_END;
            {run, score_en, game_over} <= flags_of(PERIOD_END);
          end else if (pause_toggle || shot_expire) begin
            fsm <= PAUSED;
            {run, score_en, game_over} <= flags_of(PAUSED);
          end
        end
        PAUSED: begin
          if (pause_toggle) begin
            fsm <= RUN;
            {run, score_en, game_over} <= flags_of(RUN);
          end
        end
        PERIOD_END: begin
          if (period < 3'(NUM_PERIODS)) begin
            fsm <= BREAK;
            {run, score_en, game_over} <= flags_of(BREAK);
          end else begin
            fsm <= FINAL;
            {run, score_en, game_over} <= flags_of(FINAL);
          end
        end
        BREAK: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (tick) begin
            if (brk_cnt == BW'(BREAK_SEC - 1)) begin
              fsm      <= IDLE;
              period   <= period + 3'd1;
              minutes  <= 6'(PERIOD_MIN);
              seconds  <= 6'd0;
              tick_cnt <= '0;
              brk_cnt  <= '0;
              {run, score_en, game_over} <= flags_of(IDLE);
            end else begin
              brk_cnt <= brk_cnt + 1'b1;
            end
          end
        end
        FINAL: begin
        end
        default: begin
          fsm <= IDLE;
          {run, score_en, game_over} <= flags_of(IDLE);
        end
      endcase
    end
  end

  // Buzzer runs on its own counter so it keeps sounding across state changes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buzz_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (new_game) begin
      buzz_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (buzz_trig) begin
      buzz_cnt <= ZW'(BUZZ_CYC);
      buzzer   <= 1'b1;
    end else if (buzz_cnt != '0) begin
      buzz_cnt <= buzz_cnt - 1'b1;
      buzzer   <= (buzz_cnt != ZW'(1));
    end
  end

`ifdef SHOT_CLOCK_EN
  logic [4:0] shot;

  assign shot_expire = (fsm == RUN) && tick && (shot == 5'd1) && !shot_reset && !new_game;
  assign shot_sec    = shot;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shot <= 5'(SHOT_SEC);
    end else if (new_game || shot_reset || ((fsm == IDLE) && start)) begin
      shot <= 5'(SHOT_SEC);
    end else if ((fsm == RUN) && tick && (shot != 5'd0)) begin
      shot <= shot - 5'd1;
    end
  end
`else
  logic unused_shot;

  assign shot_expire = 1'b0;
  assign shot_sec    = 5'd0;
  assign unused_shot = shot_reset ^ (SHOT_SEC == 0);
`endif

endmodule
